// File: rtl/apb_regfile_bridge_pkg.sv
// Shared types, widths and the address-check helper for the APB register-file bridge.
package apb_regfile_bridge_pkg;

  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = APB_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // True when the byte address is not word aligned or its word index is unmapped.
  function automatic logic addr_err(input logic [31:0] paddr, input int unsigned addr_w,
                                    input int unsigned num_regs);
    logic [31:0] idx;
    idx = (paddr >> 2) & ((32'd1 << addr_w) - 32'd1);
    return (paddr[1:0] != 2'b00) || (idx >= num_regs);
  endfunction

endpackage

// File: rtl/apb_regfile_addr_chk.sv
// Combinational alignment/range check and word-index extraction for a byte-addressed bus.
module apb_regfile_addr_chk
  import apb_regfile_bridge_pkg::*;
#(
  parameter int unsigned PADDR_W  = 12,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic [PADDR_W-1:0] paddr_i,
  output logic [ADDR_W-1:0]  idx_o,
  output logic               err_o
);

  assign idx_o = paddr_i[ADDR_W+1:2];
  assign err_o = addr_err(32'(paddr_i), ADDR_W, NUM_REGS);

endmodule

// File: rtl/apb_regfile_bridge.sv
// APB3 slave driving a register file's single write and read ports; all outputs registered.
// Build option APB_PSTRB_EN adds the pstrb port and byte-lane writes.
//   state      | meaning
//   ST_IDLE    | waiting for a setup phase
//   ST_WR      | write access cycle: wr_en and pready asserted
//   ST_RD_WAIT | rd_addr held while the wait counter runs down
//   ST_RESP    | read or error response: pready asserted
module apb_regfile_bridge
  import apb_regfile_bridge_pkg::*;
#(
  parameter int unsigned PADDR_W  = 12,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned RD_WAIT  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [PADDR_W-1:0]    paddr,
  input  logic [DATA_W-1:0]     pwdata,
`ifdef APB_PSTRB_EN
  input  logic [APB_STRB_W-1:0] pstrb,
`endif
  output logic [DATA_W-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [APB_STRB_W-1:0] wr_be,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data
);

  // RD_WAIT is legal from 1 to 7, so the counter starts at RD_WAIT-1 and fits in 3 bits.
  localparam logic [2:0] WAIT_INIT = 3'(RD_WAIT - 1);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_W-1:0]     prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [APB_STRB_W-1:0] wr_be_q, wr_be_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;

  logic [ADDR_W-1:0]     idx;
  logic                  err;
  logic [APB_STRB_W-1:0] strb;
  logic                  wr_pulse;
  logic                  setup;

  apb_regfile_addr_chk #(
    .PADDR_W  (PADDR_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_addr_chk (
    .paddr_i (paddr),
    .idx_o   (idx),
    .err_o   (err)
  );

`ifdef APB_PSTRB_EN
  // An all-zero strobe still completes OKAY but must not touch the register file.
  assign strb     = pstrb;
  assign wr_pulse = |pstrb;
`else
  assign strb     = '1;
  assign wr_pulse = 1'b1;
`endif

  assign setup = psel && !penable;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          if (err) begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end else if (pwrite) begin
            state_d   = ST_WR;
            pready_d  = 1'b1;
            wr_en_d   = wr_pulse;
            wr_addr_d = idx;
            wr_data_d = pwdata;
            wr_be_d   = strb;
          end else begin
            state_d   = ST_RD_WAIT;
            rd_addr_d = idx;
            cnt_d     = WAIT_INIT;
          end
        end
      end
      ST_WR: state_d = ST_IDLE;
      ST_RD_WAIT: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d  = ST_RESP;
          prdata_d = rd_data;
          pready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_be   = wr_be_q;
  assign rd_addr = rd_addr_q;

endmodule
